serial_tx_clk_rstb: RTL
=======================

Name: serial_tx_clk_rstb

Overview:
Framed serial transmitter. It is the transmit end of the team's single-wire serial link, and the receive side is serial_rx_clk_rstb. It accepts one parallel word per valid/ready handshake and shifts it out on tx_out as a frame: start bit, data bits LSB first, optional even parity, stop bit. It sits between the a/b test cores and the link pin.

Parameters:
DATA_W, 8, data bits per frame (1..16)
PARITY_EN, 1, 1 = append even parity bit; 0 = no parity bit
BIT_DIV, 4, clk cycles per serial bit (>=1)

Ports:
clk  input  1  single clock; all logic on the rising edge
rstb  input  1  asynchronous, active-low reset
in_valid  input  1  upstream word valid
in_data  input  DATA_W  upstream word
in_ready  output  1  high only in IDLE; transfer when in_valid && in_ready
tx_out  output  1  serial line; idle level 1
busy  output  1  high from the cycle after accept until the frame ends
frame_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (rstb low, asynchronous): state=IDLE, tx_out=1, in_ready=1, busy=0, frame_done=0, shift register and counters cleared.
- Reset mid-frame: the frame is abandoned immediately and tx_out returns to 1 asynchronously. No frame_done is generated.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE:
  - tx_out=1, in_ready=1, busy=0.
  - On accept, latch in_data into the shift register, compute parity = XOR of all data bits, and clear both counters.
  - Next state is START.
- Every non-IDLE state drives its bit for exactly BIT_DIV cycles. The bit timer counts 0..BIT_DIV-1; the state advances when the count reaches BIT_DIV-1.
- START: tx_out=0.
- DATA:
  - tx_out = shift_reg[0].
  - At each bit boundary, shift right and increment bit_cnt.
  - Leave DATA after DATA_W bits (bit_cnt == DATA_W-1 at the boundary).
- PARITY: tx_out = parity bit, giving an even total count of ones across data plus parity.
- STOP:
  - tx_out=1.
  - On the last stop cycle, assert frame_done (registered), so it is high in the first IDLE cycle.
  - Next state is IDLE.
- Outputs tx_out, busy and frame_done are registered. in_ready is decoded from state (== IDLE).
- Latency: tx_out falls 1 cycle after the accept edge.
- Frame length: BIT_DIV*(DATA_W+2+PARITY_EN) cycles. Defaults give 44 cycles.
- Back-to-back frames: IDLE always lasts at least 1 cycle, so the minimum accept-to-accept spacing is frame length + 1.
- Handshake rules:
  - in_valid while busy is ignored and not consumed. Upstream holds in_valid and in_data until it sees in_ready.
  - Changes to in_data after accept have no effect on the frame in flight.
- BIT_DIV=1: each bit lasts one cycle and the timer is a constant 0.
- Width rules:
  - bit_cnt width is $clog2(DATA_W) bits, minimum 1.
  - timer width is $clog2(BIT_DIV) bits, minimum 1.
  - No wrap-around beyond terminal counts; both counters clear on every state change.

Decomposition:
- Package serial_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - even-parity function
  - a frame-length constant function, shared with serial_rx_clk_rstb
- Sub-module serial_bit_timer: BIT_DIV counter with clk/rstb, clear and tick outputs. It is reused by the receiver.

Test Plan:
1. Reset then idle. Hold rstb low for 3 cycles and release with in_valid=0 -> tx_out=1, in_ready=1, busy=0, frame_done=0 for 20 cycles.
2. Single frame, defaults, in_data=8'hA5. Expected tx_out, each bit for 4 cycles:
   - bits: 0 | 1,0,1,0,0,1,0,1 | 0 (parity) | 1
   - busy high for 44 cycles
   - frame_done pulses exactly once, 45 cycles after accept
3. Parity odd-weight word. in_data=8'h01 -> parity bit=1. With PARITY_EN=0, the frame is 40 cycles and there is no parity slot.
4. Back-to-back frames. Hold in_valid=1 with 8'h3C then 8'hC3:
   - second accept occurs exactly 45 cycles after the first
   - in_ready is low throughout frame 1
   - frame 2 bits are correct
5. Handshake ignore. Pulse in_valid with 8'hFF at cycle 10 of a frame in flight, and change in_data mid-frame -> no accept, and the in-flight frame is unchanged.
6. Async reset mid-frame. Assert rstb low during DATA bit 3 -> tx_out=1 immediately without waiting for a clock edge, and no frame_done. After release, a new 8'h5A frame transmits correctly with BIT_DIV=1 (11 cycles).

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the single-wire serial link (transmitter and receiver).
// Holds the frame state encoding plus parity and frame-length helpers.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int MAX_DATA_W = 16;

    // Callers zero-extend narrower words; zeros do not change the XOR.
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] data);
        return ^data;
    endfunction

    function automatic int frame_cycles(input int data_w, input int parity_en, input int bit_div);
        return bit_div * (data_w + 2 + parity_en);
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Per-bit cycle counter: counts 0..BIT_DIV-1 and flags the last cycle of each bit.
// Held at zero while clear is high so every bit period starts aligned.
module serial_bit_timer #(
    parameter int BIT_DIV = 4
) (
    input  logic clk,
    input  logic rstb,
    input  logic clear,
    output logic tick
);

    localparam int TW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(BIT_DIV - 1);

    logic [TW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/serial_tx_clk_rstb.sv
// Framed serial transmitter: start bit, data LSB first, optional even parity, stop bit.
// Outputs are loaded with the value of the state being entered, so they change on the same edge as the state.
module serial_tx_clk_rstb
    import serial_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1,
    parameter int BIT_DIV   = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nx;
    logic [CNT_W-1:0]  bit_cnt;
    logic              parity;
    logic              tick;
    logic              timer_clear;

    assign in_ready    = (state == IDLE);
    assign timer_clear = (state == IDLE);
    assign shift_nx    = shift_reg >> 1;

    serial_bit_timer #(
        .BIT_DIV(BIT_DIV)
    ) u_timer (
        .clk  (clk),
        .rstb (rstb),
        .clear(timer_clear),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity     <= 1'b0;
            tx_out     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        parity    <= even_parity(MAX_DATA_W'(in_data));
                        bit_cnt   <= '0;
                        state     <= START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state  <= DATA;
                        tx_out <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                tx_out <= parity;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
                        end else begin
                            shift_reg <= shift_nx;
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            tx_out    <= shift_nx[0];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state      <= IDLE;
                        tx_out     <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
